// File: rtl/button_event_arbiter_if.sv
// Press-event handshake between the button arbiter and its consumer.
// The arbiter drives ev_valid/ev_id; the consumer drives ev_ready.
interface button_event_arbiter_if #(
    parameter int ID_W = 2
);
    logic            ev_valid;
    logic            ev_ready;
    logic [ID_W-1:0] ev_id;

    modport master (output ev_valid, output ev_id, input ev_ready);
    modport slave  (input ev_valid, input ev_id, output ev_ready);
endinterface

// File: rtl/button_event_arbiter.sv
// Synchronizes, debounces and edge-detects N push buttons, then serializes the
// resulting press events round-robin onto a single valid/ready event port.
module button_event_arbiter #(
    parameter int N        = 4,
    parameter int ID_W     = 2,
    parameter int DEBOUNCE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           btn,
    button_event_arbiter_if.master ev,
    output logic [N-1:0]           dropped,
    output logic [N-1:0]           db_level
);
    localparam int              CNT_W   = $clog2(DEBOUNCE) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);
    localparam logic [ID_W-1:0]  ID_LAST = ID_W'(N - 1);

    logic [N-1:0]     s1_r;
    logic [N-1:0]     s2_r;
    logic [CNT_W-1:0] cnt_r [N];
    logic [N-1:0]     db_level_r;
    logic [N-1:0]     pending_r;
    logic [N-1:0]     dropped_r;
    logic [ID_W-1:0]  rr_ptr_r;
    logic             ev_valid_r;
    logic [ID_W-1:0]  ev_id_r;

    logic [N-1:0]     rise_s;
    logic [N-1:0]     grant_oh_s;
    logic             grant_valid_s;
    logic [ID_W-1:0]  grant_id_s;
    logic             free_s;
    logic             fire_s;

    // Two-flop synchronizer per channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= '0;
            s2_r <= '0;
        end else begin
            s1_r <= btn;
            s2_r <= s1_r;
        end
    end

    // Debounce: a new level is accepted only after DEBOUNCE consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_level_r <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (s2_r[i] == db_level_r[i]) begin
                    cnt_r[i] <= '0;
                end else if (cnt_r[i] == CNT_MAX) begin
                    db_level_r[i] <= s2_r[i];
                    cnt_r[i]      <= '0;
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    // A press is the edge on which the debounced level is about to go 0->1.
    always_comb begin
        rise_s = '0;
        for (int i = 0; i < N; i++) begin
            if (!db_level_r[i] && s2_r[i] && (cnt_r[i] == CNT_MAX)) begin
                rise_s[i] = 1'b1;
            end else begin
                rise_s[i] = 1'b0;
            end
        end
    end

    // Round-robin search for the first pending channel starting at rr_ptr.
    always_comb begin
        int idx;
        idx           = 0;
        grant_valid_s = 1'b0;
        grant_id_s    = '0;
        grant_oh_s    = '0;
        free_s        = !ev_valid_r || ev.ev_ready;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr_r) + k;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            if (!grant_valid_s && pending_r[idx]) begin
                grant_valid_s = 1'b1;
                grant_id_s    = ID_W'(idx);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
        fire_s = free_s && grant_valid_s;
        for (int i = 0; i < N; i++) begin
            if (fire_s && (grant_id_s == ID_W'(i))) begin
                grant_oh_s[i] = 1'b1;
            end else begin
                grant_oh_s[i] = 1'b0;
            end
        end
    end

    // Output register, round-robin pointer, pending set/clear and drop pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_valid_r <= 1'b0;
            ev_id_r    <= '0;
            rr_ptr_r   <= '0;
            pending_r  <= '0;
            dropped_r  <= '0;
        end else begin
            if (fire_s) begin
                ev_valid_r <= 1'b1;
                ev_id_r    <= grant_id_s;
                rr_ptr_r   <= (grant_id_s == ID_LAST) ? '0 : grant_id_s + ID_W'(1);
            end else if (free_s) begin
                ev_valid_r <= 1'b0;
            end else begin
                ev_valid_r <= ev_valid_r;
            end
            for (int i = 0; i < N; i++) begin
                // A press arriving with its own grant is re-queued rather than lost.
                if (grant_oh_s[i]) begin
                    pending_r[i] <= rise_s[i];
                    dropped_r[i] <= 1'b0;
                end else if (rise_s[i]) begin
                    pending_r[i] <= 1'b1;
                    dropped_r[i] <= pending_r[i];
                end else begin
                    dropped_r[i] <= 1'b0;
                end
            end
        end
    end

    assign ev.ev_valid = ev_valid_r;
    assign ev.ev_id    = ev_id_r;
    assign dropped     = dropped_r;
    assign db_level    = db_level_r;
endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Controller that turns N raw push-button inputs into a serialized stream of press events. Each button input is synchronized, debounced and single-pulsed. Pending presses are then granted round-robin onto one valid/ready event port. It sits between the board buttons and any consumer FSM, such as a menu or counter controller. It replaces per-button single-pulser instances wherever several buttons share one consumer.

## Interface
- N, 4, number of button channels (2..8)
- ID_W, 2, event id width; must satisfy 2^ID_W >= N
- DEBOUNCE, 4, consecutive cycles a level must hold before it is accepted (>= 1)
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- btn  input  N  raw asynchronous button levels, 1 = pressed
- ev_ready  input  1  consumer accepts ev_id on a cycle where ev_valid=1
- ev_valid  output  1  an event is presented on ev_id
- ev_id  output  ID_W  index of the button whose press is presented
- dropped  output  N  one-cycle pulse per channel when a press is lost
- db_level  output  N  debounced button levels (for LEDs/debug)

One clock; reset is asynchronous and active-low.

## Operation
- **Reset (rst_n=0).** Clears all state immediately, independent of clk.
  - ev_valid=0, ev_id=0, dropped=0, db_level=0.
  - Sync flops=0, debounce counters=0, pending=0, rr_ptr=0.
- **Synchronizer.** Per channel, two flops: s1<=btn[i], then s2<=s1.
- **Debounce.** Per channel, counter cnt (width $clog2(DEBOUNCE)+1).
  - If s2==db_level[i]: cnt<=0.
  - Else if cnt==DEBOUNCE-1: db_level[i]<=s2 and cnt<=0.
  - Else: cnt<=cnt+1.
  - A level differing for fewer than DEBOUNCE consecutive edges is ignored.
- **Press detect.** rise[i] is asserted on the edge where db_level[i] goes 0->1. Releases (1->0) generate no event.
- **Pending.** pending[i] is set by rise[i] and cleared by a grant of channel i.
  - If rise[i] and a grant of i occur on the same edge, pending stays 1. The new press is queued.
  - If rise[i] and pending[i]=1 with no grant of i on that edge, the press is lost. dropped[i]=1 for exactly one cycle; pending is unchanged.
- **Output register.** free = !ev_valid || ev_ready.
- **Arbitration.** Round-robin, evaluated when free && |pending.
  - grant = first i with pending[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping mod N.
  - On that edge: ev_valid<=1, ev_id<=grant, pending[grant]<=0, rr_ptr<=(grant+1) mod N.
- **Acceptance without re-grant.** If free and no pending bit is set: ev_valid<=0 and ev_id holds its value.
- **Stall.** While ev_valid && !ev_ready, ev_id and ev_valid are held stable. Rises during a stall still set pending.

## Timing
- **Press to event latency.** Let edge 0 be the first edge that samples btn[i]=1, with btn stable high afterwards.
  - s2=1 after edge 1.
  - db_level and pending set at edge DEBOUNCE+1.
  - ev_valid=1 after edge DEBOUNCE+2, i.e. 6 edges for DEBOUNCE=4, provided the output is free.
- **Throughput.** With ev_ready held at 1, one event per cycle is issued back-to-back.
- **Simultaneous presses.** Events for presses becoming pending on the same edge are issued in round-robin order starting from rr_ptr, on consecutive cycles.
- **Async reset.** Asserting rst_n mid-operation drops ev_valid in the same cycle, asynchronously. All pending presses are discarded.
- **Reset release.** A button already held at deassertion produces one event DEBOUNCE+2 edges after deassertion, since db_level restarts at 0.

## Test plan
Conditions: clk period 20 ns, N=4, DEBOUNCE=4, ev_ready=1 unless stated.
- **Single press.** rst_n released at 15 ns; btn[2]=1 just before edge 0 (55 ns), held 200 ns.
  - Expect exactly one cycle of ev_valid=1 with ev_id=2, rising after edge 6.
  - Expect db_level[2]=1 after edge 5, and no event on release.
- **Glitch rejection.** btn[0] high for 3 cycles, low 3 cycles, high 2 cycles.
  - Expect db_level[0] never 1, no ev_valid, dropped=0.
- **Simultaneous press, rr_ptr=0.** btn[3] and btn[1] rise on the same edge.
  - Expect ev_id=1 then ev_id=3 on consecutive cycles, ending with rr_ptr=0.
  - Repeat: the same pair issues 1, 3 again.
  - Then press btn[1] alone: ev_id=1.
- **Back-pressure.** ev_ready=0; press btn[0], then btn[1].
  - Expect ev_valid=1, ev_id=0 held stable for 10 cycles.
  - After ev_ready=1 for one cycle, expect ev_id=1 on the next cycle.
- **Drop.** ev_ready=0 with channel 0 already presented. Press and release btn[1] twice, each phase 6 cycles.
  - Expect dropped[1] to pulse for one cycle on the second rise.
  - After ev_ready=1, expect only one ev_id=1 event.
- **Async reset mid-stall.** While ev_valid=1 and pending=4'b0110, pulse rst_n low for 5 ns between edges.
  - Expect ev_valid=0 immediately and no further events.
